// File: rtl/nf10_switch_pkg.sv
// Shared types and defaults for the NF10 switch input arbiter.
package nf10_switch_pkg;

    localparam int unsigned DEFAULT_NUM_PORTS   = 4;
    localparam int unsigned DEFAULT_DATA_WIDTH  = 256;
    localparam int unsigned DEFAULT_TUSER_WIDTH = 128;
    localparam int unsigned PKT_CNT_WIDTH       = 32;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    // Width of a port index; never narrower than one bit.
    function automatic int unsigned port_index_width(input int unsigned num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/nf10_switch_input_arbiter_if.sv
// AXI-Stream bundle with NUM_LANES parallel lanes packed side by side.
interface nf10_switch_input_arbiter_if
    import nf10_switch_pkg::*;
#(
    parameter int unsigned NUM_LANES   = 1,
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned TUSER_WIDTH = DEFAULT_TUSER_WIDTH
);

    logic [NUM_LANES*DATA_WIDTH-1:0]     tdata;
    logic [NUM_LANES*DATA_WIDTH/8-1:0]   tstrb;
    logic [NUM_LANES*TUSER_WIDTH-1:0]    tuser;
    logic [NUM_LANES-1:0]                tvalid;
    logic [NUM_LANES-1:0]                tlast;
    logic [NUM_LANES-1:0]                tready;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);

endinterface

// File: rtl/nf10_rr_select.sv
// Combinational round-robin pick: first requester after last_ptr, with wrap.
module nf10_rr_select
    import nf10_switch_pkg::*;
#(
    parameter int unsigned NUM_PORTS = DEFAULT_NUM_PORTS,
    parameter int unsigned PTR_WIDTH = port_index_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_WIDTH-1:0] last_ptr,
    output logic [PTR_WIDTH-1:0] winner,
    output logic                 any_req
);

    logic [PTR_WIDTH-1:0] cand;
    logic                 found;

    // Scan ports last_ptr+1 .. last_ptr+NUM_PORTS (mod NUM_PORTS); first hit wins.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            cand = PTR_WIDTH'((32'(last_ptr) + k) % NUM_PORTS);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/nf10_switch_input_arbiter.sv
// Packet-granular round-robin merge of C_NUM_PORTS AXI-Stream inputs into one.
module nf10_switch_input_arbiter
    import nf10_switch_pkg::*;
#(
    parameter int unsigned C_NUM_PORTS        = DEFAULT_NUM_PORTS,
    parameter int unsigned C_AXIS_DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned C_AXIS_TUSER_WIDTH = DEFAULT_TUSER_WIDTH
) (
    input  logic                                 S_AXI_ACLK,
    input  logic                                 S_AXI_ARESET,
    nf10_switch_input_arbiter_if.slave           s_axis,
    nf10_switch_input_arbiter_if.master          m_axis,
    output logic [C_NUM_PORTS*PKT_CNT_WIDTH-1:0] PKT_CNT
);

    localparam int unsigned PTR_WIDTH  = port_index_width(C_NUM_PORTS);
    localparam int unsigned STRB_WIDTH = C_AXIS_DATA_WIDTH / 8;

    state_t                               state;
    logic [PTR_WIDTH-1:0]                 rr_ptr;
    logic [PTR_WIDTH-1:0]                 grant;
    logic [PTR_WIDTH-1:0]                 winner;
    logic                                 any_req;
    logic                                 xfer;
    logic [C_NUM_PORTS*PKT_CNT_WIDTH-1:0] pkt_cnt;

    nf10_rr_select #(
        .NUM_PORTS (C_NUM_PORTS),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_rr_select (
        .req      (s_axis.tvalid),
        .last_ptr (rr_ptr),
        .winner   (winner),
        .any_req  (any_req)
    );

    // Route the granted lane to the output; only that lane sees downstream ready.
    always_comb begin
        m_axis.tdata  = s_axis.tdata[32'(grant)*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
        m_axis.tstrb  = s_axis.tstrb[32'(grant)*STRB_WIDTH +: STRB_WIDTH];
        m_axis.tuser  = s_axis.tuser[32'(grant)*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
        m_axis.tlast  = s_axis.tlast[grant];
        m_axis.tvalid = (state == SEND) && s_axis.tvalid[grant];
        s_axis.tready = '0;
        if (state == SEND) begin
            s_axis.tready[grant] = m_axis.tready[0];
        end
    end

    assign xfer = m_axis.tvalid[0] & m_axis.tready[0];

    // Arbitration FSM: IDLE spends one bubble cycle picking, SEND holds until TLAST.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state   <= IDLE;
            rr_ptr  <= PTR_WIDTH'(C_NUM_PORTS - 1);
            grant   <= '0;
            pkt_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        grant <= winner;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (xfer && m_axis.tlast[0]) begin
                        rr_ptr <= grant;
                        state  <= IDLE;
                        pkt_cnt[32'(grant)*PKT_CNT_WIDTH +: PKT_CNT_WIDTH] <=
                            pkt_cnt[32'(grant)*PKT_CNT_WIDTH +: PKT_CNT_WIDTH] +
                            PKT_CNT_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign PKT_CNT = pkt_cnt;

endmodule

// File: tb/tb_nf10_switch_input_arbiter.sv
// Self-checking bench: packet sources, random back-pressure, and a
// packet-level round-robin reference model.
module tb_nf10_switch_input_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int TW = 16;
    localparam int SW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [TW-1:0] user;
        logic          last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP*32-1:0] pkt_cnt;

    nf10_switch_input_arbiter_if #(.NUM_LANES(NP), .DATA_WIDTH(DW), .TUSER_WIDTH(TW)) s_if ();
    nf10_switch_input_arbiter_if #(.NUM_LANES(1), .DATA_WIDTH(DW), .TUSER_WIDTH(TW)) m_if ();

    nf10_switch_input_arbiter #(
        .C_NUM_PORTS        (NP),
        .C_AXIS_DATA_WIDTH  (DW),
        .C_AXIS_TUSER_WIDTH (TW)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .PKT_CNT      (pkt_cnt)
    );

    always #5 clk = ~clk;

    int          tests_run = 0;
    int          tests_failed = 0;
    beat_t       src_q[NP][$];
    beat_t       exp_q[$];
    beat_t       obs_q[$];
    int          exp_order[$];
    logic [31:0] exp_cnt[NP];
    int          model_ptr;
    bit          mid[NP];
    int          start_at[NP];
    logic [63:0] drop_mask[NP];
    logic [63:0] ready_low;
    int          ready_pct;
    int          gap_pct;
    int          last_xfer;
    logic        obs_mvalid[128];
    logic [NP-1:0] obs_sready[128];

    task automatic drive_idle();
        s_if.tdata  = '0;
        s_if.tstrb  = '0;
        s_if.tuser  = '0;
        s_if.tvalid = '0;
        s_if.tlast  = '0;
        m_if.tready = '0;
    endtask

    task automatic cfg_default();
        for (int p = 0; p < NP; p++) begin
            start_at[p]  = 0;
            drop_mask[p] = '0;
            src_q[p].delete();
        end
        ready_low = '0;
        ready_pct = 100;
        gap_pct   = 0;
        exp_order.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        model_ptr = NP - 1;
        for (int p = 0; p < NP; p++) begin
            exp_cnt[p] = '0;
            mid[p]     = 1'b0;
        end
        cfg_default();
    endtask

    task automatic add_packet(input int port, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = $urandom();
            b.strb = SW'($urandom());
            b.user = TW'($urandom());
            b.last = (i == len - 1);
            src_q[port].push_back(b);
        end
    endtask

    // Reference: whole packets leave in round-robin order (or a given order),
    // each one bumping its port's 32-bit counter.
    function automatic void build_expected(input bit use_order);
        beat_t tmp[NP][$];
        beat_t b;
        int    p;
        int    oi;
        for (int i = 0; i < NP; i++) tmp[i] = src_q[i];
        exp_q.delete();
        oi = 0;
        while (1) begin
            p = -1;
            if (use_order) begin
                if (oi < exp_order.size()) begin
                    p = exp_order[oi];
                    oi++;
                end
            end else begin
                for (int k = 1; k <= NP; k++) begin
                    if (p < 0 && tmp[(model_ptr + k) % NP].size() > 0) p = (model_ptr + k) % NP;
                end
            end
            if (p < 0) break;
            b = '0;
            while (!b.last && tmp[p].size() > 0) begin
                b = tmp[p].pop_front();
                exp_q.push_back(b);
            end
            exp_cnt[p] = exp_cnt[p] + 32'd1;
            model_ptr  = p;
        end
    endfunction

    task automatic run_traffic(input int max_cycles);
        beat_t h;
        beat_t o;
        bit    busy;
        bit    v;
        obs_q.delete();
        last_xfer = -1;
        busy = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                v = 1'b0;
                if (src_q[p].size() > 0 && c >= start_at[p] && !(c < 64 && drop_mask[p][c]))
                    v = !mid[p] || ($urandom_range(99) >= gap_pct);
                if (v) begin
                    h = src_q[p][0];
                end else begin
                    h.data = $urandom();
                    h.strb = SW'($urandom());
                    h.user = TW'($urandom());
                    h.last = 1'($urandom_range(1));
                end
                s_if.tdata[p*DW +: DW] = h.data;
                s_if.tstrb[p*SW +: SW] = h.strb;
                s_if.tuser[p*TW +: TW] = h.user;
                s_if.tlast[p]          = h.last;
                s_if.tvalid[p]         = v;
            end
            m_if.tready[0] = !(c < 64 && ready_low[c]) && ($urandom_range(99) < ready_pct);
            #1;
            if (c < 128) begin
                obs_mvalid[c] = m_if.tvalid[0];
                obs_sready[c] = s_if.tready;
            end
            if (m_if.tvalid[0] && m_if.tready[0]) begin
                o.data = m_if.tdata;
                o.strb = m_if.tstrb;
                o.user = m_if.tuser;
                o.last = m_if.tlast[0];
                obs_q.push_back(o);
                last_xfer = c;
            end
            busy = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if (s_if.tvalid[p] && s_if.tready[p]) begin
                    h = src_q[p].pop_front();
                    mid[p] = !h.last;
                end
                if (src_q[p].size() > 0) busy = 1'b1;
            end
            if (!busy) break;
        end
        if (busy) begin
            tests_run++;
            tests_failed++;
            $display("FAIL timeout: sources not drained within %0d cycles", max_cycles);
        end
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic test_reset();
        logic [DW-1:0] pat;
        drive_idle();
        for (int p = 0; p < NP; p++) s_if.tdata[p*DW +: DW] = 32'hA0 + p;
        s_if.tvalid    = '1;
        m_if.tready[0] = 1'b1;
        @(negedge clk);
        tests_run++;
        if (m_if.tvalid[0] !== 1'b0 || s_if.tready !== '0 || pkt_cnt !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: mvalid=%b sready=%b cnt=%h, required 0/0/0",
                     m_if.tvalid[0], s_if.tready, pkt_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        pat = 32'hA0;
        tests_run++;
        if (s_if.tready !== 4'b0001 || m_if.tdata !== pat) begin
            tests_failed++;
            $display("FAIL reset_first_grant: sready=%b data=%h, required 0001/%h",
                     s_if.tready, m_if.tdata, pat);
        end
        do_reset();
    endtask

    task automatic test_round_robin();
        int bubbles;
        do_reset();
        for (int p = 0; p < NP; p++) add_packet(p, 3);
        build_expected(1'b0);
        run_traffic(200);
        tests_run++;
        if (obs_q.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL rr_beats: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL rr_beat[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (last_xfer !== 15) begin
            tests_failed++;
            $display("FAIL rr_cycles: last beat at cycle %0d, required 15", last_xfer);
        end
        bubbles = 0;
        for (int c = 0; c <= last_xfer && c < 128; c++) if (!obs_mvalid[c]) bubbles++;
        tests_run++;
        if (bubbles !== 4) begin
            tests_failed++;
            $display("FAIL rr_bubbles: got %0d idle cycles, required 4", bubbles);
        end
        for (int p = 0; p < NP; p++) begin
            tests_run++;
            if (pkt_cnt[p*32 +: 32] !== exp_cnt[p]) begin
                tests_failed++;
                $display("FAIL rr_cnt[%0d]: got %0d required %0d", p, pkt_cnt[p*32 +: 32], exp_cnt[p]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        add_packet(2, 5);
        add_packet(1, 2);
        start_at[1] = 3;
        ready_low   = 64'h1C;
        exp_order   = '{2, 1};
        build_expected(1'b1);
        run_traffic(200);
        tests_run++;
        if (obs_q.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL bp_beats: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL bp_beat[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (last_xfer !== 11) begin
            tests_failed++;
            $display("FAIL bp_cycles: last beat at cycle %0d, required 11", last_xfer);
        end
        for (int c = 2; c <= 4; c++) begin
            tests_run++;
            if (obs_mvalid[c] !== 1'b1 || obs_sready[c] !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: mvalid=%b sready=%b, required 1/0000",
                         c, obs_mvalid[c], obs_sready[c]);
            end
        end
        for (int p = 0; p < NP; p++) begin
            tests_run++;
            if (pkt_cnt[p*32 +: 32] !== exp_cnt[p]) begin
                tests_failed++;
                $display("FAIL bp_cnt[%0d]: got %0d required %0d", p, pkt_cnt[p*32 +: 32], exp_cnt[p]);
            end
        end
    endtask

    task automatic test_alternation();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            add_packet(0, 1);
            add_packet(3, 1);
        end
        build_expected(1'b0);
        run_traffic(200);
        tests_run++;
        if (obs_q.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL alt_beats: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL alt_beat[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (last_xfer !== 15) begin
            tests_failed++;
            $display("FAIL alt_cycles: last beat at cycle %0d, required 15", last_xfer);
        end
        for (int p = 0; p < NP; p++) begin
            tests_run++;
            if (pkt_cnt[p*32 +: 32] !== exp_cnt[p]) begin
                tests_failed++;
                $display("FAIL alt_cnt[%0d]: got %0d required %0d", p, pkt_cnt[p*32 +: 32], exp_cnt[p]);
            end
        end
    endtask

    task automatic test_valid_drop();
        do_reset();
        add_packet(1, 4);
        add_packet(0, 2);
        start_at[0]  = 1;
        drop_mask[1] = 64'hC;
        exp_order    = '{1, 0};
        build_expected(1'b1);
        run_traffic(200);
        tests_run++;
        if (obs_q.size() !== exp_q.size()) begin
            tests_failed++;
            $display("FAIL drop_beats: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL drop_beat[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        for (int c = 2; c <= 3; c++) begin
            tests_run++;
            if (obs_mvalid[c] !== 1'b0 || obs_sready[c] !== 4'b0010) begin
                tests_failed++;
                $display("FAIL drop_hold[%0d]: mvalid=%b sready=%b, required 0/0010",
                         c, obs_mvalid[c], obs_sready[c]);
            end
        end
        tests_run++;
        if (last_xfer !== 9) begin
            tests_failed++;
            $display("FAIL drop_cycles: last beat at cycle %0d, required 9", last_xfer);
        end
    endtask

    task automatic test_reset_mid();
        drive_idle();
        s_if.tdata[2*DW +: DW] = 32'hBEEF0002;
        s_if.tvalid[2]         = 1'b1;
        m_if.tready[0]         = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (m_if.tvalid[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_pre: mvalid=%b before reset, required 1", m_if.tvalid[0]);
        end
        rst = 1'b1;
        for (int p = 0; p < NP; p++) exp_cnt[p] = '0;
        #1;
        tests_run++;
        if (m_if.tvalid[0] !== 1'b0 || s_if.tready !== '0 || pkt_cnt !== '0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: mvalid=%b sready=%b cnt=%h, required 0/0/0",
                     m_if.tvalid[0], s_if.tready, pkt_cnt);
        end
        for (int p = 0; p < NP; p++) s_if.tdata[p*DW +: DW] = 32'hC0 + p;
        s_if.tvalid = '1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (s_if.tready !== 4'b0001 || m_if.tdata !== 32'hC0) begin
            tests_failed++;
            $display("FAIL midrst_grant: sready=%b data=%h, required 0001/000000c0",
                     s_if.tready, m_if.tdata);
        end
        do_reset();
    endtask

    task automatic test_pkt_cnt_wrap();
        do_reset();
        force dut.pkt_cnt = {{((NP-1)*32){1'b0}}, 32'hFFFFFFFF};
        @(negedge clk);
        release dut.pkt_cnt;
        exp_cnt[0] = 32'hFFFFFFFF;
        add_packet(0, 1);
        build_expected(1'b0);
        run_traffic(50);
        for (int p = 0; p < NP; p++) begin
            tests_run++;
            if (pkt_cnt[p*32 +: 32] !== exp_cnt[p]) begin
                tests_failed++;
                $display("FAIL wrap_cnt[%0d]: got %h required %h", p, pkt_cnt[p*32 +: 32], exp_cnt[p]);
            end
        end
    endtask

    task automatic test_random();
        int n;
        do_reset();
        for (int r = 0; r < 6; r++) begin
            cfg_default();
            ready_pct = 60;
            gap_pct   = 30;
            for (int p = 0; p < NP; p++) begin
                n = $urandom_range(0, 3);
                for (int k = 0; k < n; k++) add_packet(p, $urandom_range(1, 6));
            end
            if (src_q[r % NP].size() == 0) add_packet(r % NP, $urandom_range(1, 6));
            build_expected(1'b0);
            run_traffic(3000);
            tests_run++;
            if (obs_q.size() !== exp_q.size()) begin
                tests_failed++;
                $display("FAIL rand%0d_beats: got %0d beats, required %0d", r, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                tests_run++;
                if (obs_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL rand%0d_beat[%0d]: got %h required %h", r, i, obs_q[i], exp_q[i]);
                end
            end
            for (int p = 0; p < NP; p++) begin
                tests_run++;
                if (pkt_cnt[p*32 +: 32] !== exp_cnt[p]) begin
                    tests_failed++;
                    $display("FAIL rand%0d_cnt[%0d]: got %0d required %0d",
                             r, p, pkt_cnt[p*32 +: 32], exp_cnt[p]);
                end
            end
        end
    endtask

    initial begin
        model_ptr = NP - 1;
        for (int p = 0; p < NP; p++) begin
            exp_cnt[p] = '0;
            mid[p]     = 1'b0;
        end
        cfg_default();
        test_reset();
        test_round_robin();
        test_backpressure();
        test_alternation();
        test_valid_drop();
        test_reset_mid();
        test_pkt_cnt_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
